div_issue_ctrl: RTL and testbench
=================================

// Module: div_issue_ctrl
// PURPOSE
//  Sequences the EXE-stage divider IPs: the signed divider (index 0) and the unsigned divider (index 1), both AXI-stream.
//  Accepts one div/mod request from EXE, drives each operand channel exactly once, waits for the quotient/remainder,
//  registers and holds the selected result until EXE consumes it, and drains results orphaned by a pipeline flush.
//  One divide is in flight at a time. The IPs never see a duplicated or dropped operand beat.
// PARAMETERS
//  DW        32   operand/result width
//  TO_CYC    64   watchdog limit: max cycles in WAIT/DRAIN before err pulses
// PORTS
//  clk          in   1      clock
//  reset        in   1      synchronous reset, active-high
//  req_valid    in   1      EXE presents a divide op
//  req_ready    out  1      controller accepts (IDLE only)
//  req_op       in   2      [0]=1 remainder, 0 quotient; [1]=1 unsigned (IP 1), 0 signed (IP 0)
//  req_src1     in   DW     dividend
//  req_src2     in   DW     divisor
//  flush        in   1      cancel current op (EXE flush/exception), single-cycle pulse
//  res_valid    out  1      result held
//  res_ready    in   1      EXE consumes result (MEM_allow_in)
//  res_data     out  DW     selected quotient or remainder
//  busy         out  1      state != IDLE
//  err          out  1      one-cycle pulse on watchdog expiry
//  dvd_tdata    out  DW     dividend, shared by both IPs
//  dvd_tvalid   out  2      per-IP dividend valid
//  dvd_tready   in   2      per-IP dividend ready
//  dvs_tdata    out  DW     divisor, shared by both IPs
//  dvs_tvalid   out  2      per-IP divisor valid
//  dvs_tready   in   2      per-IP divisor ready
//  dout_tvalid  in   2      per-IP result valid
//  dout_tdata   in   4*DW   {IP1[2DW-1:0], IP0[2DW-1:0]}; in each IP slice, [2DW-1:DW] = quotient, [DW-1:0] = remainder
// BEHAVIOUR
//  Reset: state=IDLE. All tvalid=0, res_valid=0, res_data=0, busy=0, err=0, req_ready=1, flags and watchdog cleared.
//  FSM states: IDLE, ISSUE, WAIT, DONE, DRAIN.
//  IDLE: req_ready=1. On req_valid, latch op/src1/src2 and sel=req_op[1], clear dvd_sent/dvs_sent, go to ISSUE next cycle.
//  ISSUE: the tvalid[sel] of each channel = ~sent for that channel. tdata comes from the latches and is stable while valid.
//   A channel's sent flag sets on its valid&ready. Channels complete independently.
//   Once both flags are set, or both handshakes complete in the same cycle, go to WAIT.
//  WAIT: on dout_tvalid[sel], capture the quotient or remainder per op[0] into res_data, go to DONE.
//  DONE: res_valid=1 and res_data held. On res_ready, go to IDLE; the next req is accepted the cycle after that.
//  Latency: the IP's latency + 2 cycles (ISSUE at T+1 with zero-wait tready; res_valid the cycle after dout_tvalid).
//  Flush rules:
//   IDLE, or same cycle as the req handshake: flush wins, req dropped, state stays IDLE.
//   ISSUE with neither channel sent: go to IDLE, tvalid deasserted next cycle.
//   ISSUE with one channel sent: finish the remaining channel (IP pairing must not skew), then go to DRAIN.
//   WAIT: go to DRAIN. DONE: go to IDLE, result discarded, res_valid=0 next cycle.
//   DRAIN: flush ignored.
//  DRAIN: res_valid=0. Consume dout_tvalid[sel] silently, then go to IDLE.
//  dout_tvalid on the unselected IP, or in IDLE/ISSUE: ignored (no state change).
//  Watchdog: counts cycles in WAIT/DRAIN and clears on state entry.
//   When it reaches TO_CYC: err pulses for 1 cycle, state goes to IDLE, and all flags clear.
//  Arithmetic: no transformation; signedness comes purely from IP selection. Divide-by-zero passes IP output through unchanged.
//  Reset mid-operation: everything returns to the reset values next cycle. A stale IP output after reset lands in IDLE and is ignored.
// TESTING
//  1 div signed -7/2, op=00, readys=1, IP latency 6 -> res_valid at accept+8, res_data=0xFFFFFFFD; mod (op=01) -> 0xFFFFFFFF.
//  2 divu 0xFFFFFFFF/0x10, op=11 -> only *_tvalid[1] asserted, res_data=0x0000000F; *_tvalid[0] never set.
//  3 dvd_tready=1, dvs_tready low 5 cycles -> dvd_tvalid one cycle only, dvs_tvalid held 5+1 cycles, single pairing.
//  4 flush after dividend only sent -> divisor still sent once, DRAIN swallows dout, res_valid never set, then IDLE.
//  5 res_ready low 10 cycles in DONE -> res_data stable, req_ready=0 throughout; flush in DONE -> IDLE next cycle.
//  6 dout_tvalid withheld, TO_CYC=64 -> err pulse at WAIT entry+64, busy=0 next cycle; reset in WAIT -> IDLE, outputs 0.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// Issue controller for the signed (IP 0) and unsigned (IP 1) AXI-stream dividers.
// One divide in flight; each operand beat is sent exactly once, even across a flush.
module div_issue_ctrl #(
    parameter int DW     = 32,
    parameter int TO_CYC = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [DW-1:0]   req_src1,
    input  logic [DW-1:0]   req_src2,
    input  logic            flush,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [DW-1:0]   res_data,
    output logic            busy,
    output logic            err,
    output logic [DW-1:0]   dvd_tdata,
    output logic [1:0]      dvd_tvalid,
    input  logic [1:0]      dvd_tready,
    output logic [DW-1:0]   dvs_tdata,
    output logic [1:0]      dvs_tvalid,
    input  logic [1:0]      dvs_tready,
    input  logic [1:0]      dout_tvalid,
    input  logic [4*DW-1:0] dout_tdata
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    localparam int             WDW    = $clog2(TO_CYC + 1);
    localparam logic [WDW-1:0] TO_LIM = WDW'(TO_CYC);

    logic [2:0]     state_q, state_d;
    logic [1:0]     op_q, op_d;
    logic [DW-1:0]  src1_q, src1_d;
    logic [DW-1:0]  src2_q, src2_d;
    logic           dvdSent_q, dvdSent_d;
    logic           dvsSent_q, dvsSent_d;
    logic           flushPend_q, flushPend_d;
    logic [DW-1:0]  resData_q, resData_d;
    logic [WDW-1:0] wd_q, wd_d;

    logic            sel;
    logic            dvdFire, dvsFire, dvdDone, dvsDone, pendNext;
    logic            doutHit, waiting, timeout;
    logic [2*DW-1:0] ipResult;
    logic [DW-1:0]   picked;

    assign sel      = op_q[1];
    assign dvdFire  = (state_q == S_ISSUE) && !dvdSent_q && dvd_tready[sel];
    assign dvsFire  = (state_q == S_ISSUE) && !dvsSent_q && dvs_tready[sel];
    assign dvdDone  = dvdSent_q | dvdFire;
    assign dvsDone  = dvsSent_q | dvsFire;
    assign pendNext = flushPend_q | flush;
    assign doutHit  = dout_tvalid[sel];
    assign waiting  = (state_q == S_WAIT) || (state_q == S_DRAIN);
    assign timeout  = waiting && (wd_q == TO_LIM);
    assign ipResult = sel ? dout_tdata[4*DW-1:2*DW] : dout_tdata[2*DW-1:0];
    assign picked   = op_q[0] ? ipResult[DW-1:0] : ipResult[2*DW-1:DW];

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        src1_d      = src1_q;
        src2_d      = src2_q;
        dvdSent_d   = dvdSent_q;
        dvsSent_d   = dvsSent_q;
        flushPend_d = flushPend_q;
        resData_d   = resData_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && !flush) begin
                    op_d    = req_op;
                    src1_d  = req_src1;
                    src2_d  = req_src2;
                    state_d = S_ISSUE;
                end
            end
            // A flush after any beat has gone out must still finish the pair.
            S_ISSUE: begin
                dvdSent_d = dvdDone;
                dvsSent_d = dvsDone;
                if (flush && !dvdDone && !dvsDone) begin
                    state_d = S_IDLE;
                end else begin
                    flushPend_d = pendNext;
                    if (dvdDone && dvsDone) begin
                        state_d = pendNext ? S_DRAIN : S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (timeout) begin
                    state_d = S_IDLE;
                end else if (doutHit) begin
                    if (flush) begin
                        state_d = S_IDLE;
                    end else begin
                        resData_d = picked;
                        state_d   = S_DONE;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                if (flush || res_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (timeout || doutHit) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_IDLE) begin
            dvdSent_d   = 1'b0;
            dvsSent_d   = 1'b0;
            flushPend_d = 1'b0;
        end
    end

    // Watchdog restarts on every state change and only advances in WAIT/DRAIN.
    always_comb begin
        wd_d = '0;
        if (waiting && (state_d == state_q)) begin
            wd_d = wd_q + WDW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            dvdSent_q   <= 1'b0;
            dvsSent_q   <= 1'b0;
            flushPend_q <= 1'b0;
            resData_q   <= '0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            dvdSent_q   <= dvdSent_d;
            dvsSent_q   <= dvsSent_d;
            flushPend_q <= flushPend_d;
            resData_q   <= resData_d;
            wd_q        <= wd_d;
        end
    end

    always_comb begin
        dvd_tvalid = 2'b00;
        dvs_tvalid = 2'b00;
        if (state_q == S_ISSUE) begin
            dvd_tvalid[sel] = !dvdSent_q;
            dvs_tvalid[sel] = !dvsSent_q;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign res_valid = (state_q == S_DONE);
    assign res_data  = resData_q;
    assign err       = timeout;
    assign dvd_tdata = src1_q;
    assign dvs_tdata = src2_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl: the divider IPs are played by hand-timed dout beats.
module tb_div_issue_ctrl;

    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [DW-1:0]   req_src1;
    logic [DW-1:0]   req_src2;
    logic            flush;
    logic            res_valid;
    logic            res_ready;
    logic [DW-1:0]   res_data;
    logic            busy;
    logic            err;
    logic [DW-1:0]   dvd_tdata;
    logic [1:0]      dvd_tvalid;
    logic [1:0]      dvd_tready;
    logic [DW-1:0]   dvs_tdata;
    logic [1:0]      dvs_tvalid;
    logic [1:0]      dvs_tready;
    logic [1:0]      dout_tvalid;
    logic [4*DW-1:0] dout_tdata;

    int nChecks = 0;
    int nPass   = 0;
    int dvdBeats[2];
    int dvsBeats[2];

    div_issue_ctrl #(.DW(DW), .TO_CYC(64)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_src1(req_src1), .req_src2(req_src2), .flush(flush),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .err(err),
        .dvd_tdata(dvd_tdata), .dvd_tvalid(dvd_tvalid), .dvd_tready(dvd_tready),
        .dvs_tdata(dvs_tdata), .dvs_tvalid(dvs_tvalid), .dvs_tready(dvs_tready),
        .dout_tvalid(dout_tvalid), .dout_tdata(dout_tdata)
    );

    always #5 clk = ~clk;

    // Operand beats actually accepted by each IP.
    initial begin
        dvdBeats[0] = 0; dvdBeats[1] = 0;
        dvsBeats[0] = 0; dvsBeats[1] = 0;
    end
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (dvd_tvalid[i] && dvd_tready[i]) dvdBeats[i] <= dvdBeats[i] + 1;
            if (dvs_tvalid[i] && dvs_tready[i]) dvsBeats[i] <= dvsBeats[i] + 1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic startOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op    = op;
        req_src1  = a;
        req_src2  = b;
        req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        nChecks++;
        if ({req_ready, busy, res_valid, err} !== 4'b1000)
            $display("[TB] FAIL reset_ctrl got rdy/busy/rv/err=%b want 1000", {req_ready, busy, res_valid, err});
        else nPass++;
        nChecks++;
        if ({dvd_tvalid, dvs_tvalid} !== 4'b0000 || res_data !== 32'h0)
            $display("[TB] FAIL reset_data got tvalid=%b res_data=%h want 0000/0", {dvd_tvalid, dvs_tvalid}, res_data);
        else nPass++;
    endtask

    task automatic test_div_signed;
        logic [1:0]  ops[2];
        logic [31:0] want[2];
        ops[0] = 2'b00; want[0] = 32'hFFFF_FFFD;
        ops[1] = 2'b01; want[1] = 32'hFFFF_FFFF;
        dvd_tready = 2'b11;
        dvs_tready = 2'b11;
        for (int k = 0; k < 2; k++) begin
            startOp(ops[k], 32'hFFFF_FFF9, 32'h2);
            nChecks++;
            if (dvd_tvalid !== 2'b01 || dvs_tvalid !== 2'b01)
                $display("[TB] FAIL signed_issue_valid got dvd=%b dvs=%b want 01/01", dvd_tvalid, dvs_tvalid);
            else nPass++;
            nChecks++;
            if (dvd_tdata !== 32'hFFFF_FFF9 || dvs_tdata !== 32'h2)
                $display("[TB] FAIL signed_issue_data got %h/%h want fffffff9/2", dvd_tdata, dvs_tdata);
            else nPass++;
            tick;
            repeat (5) tick;
            nChecks++;
            if (res_valid !== 1'b0)
                $display("[TB] FAIL signed_early_result got res_valid=%b want 0", res_valid);
            else nPass++;
            dout_tdata  = {64'h0, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
            dout_tvalid = 2'b01;
            tick;
            dout_tvalid = 2'b00;
            nChecks++;
            if (res_valid !== 1'b1 || res_data !== want[k])
                $display("[TB] FAIL signed_result got rv=%b data=%h want 1/%h", res_valid, res_data, want[k]);
            else nPass++;
            res_ready = 1'b1;
            tick;
            res_ready = 1'b0;
            nChecks++;
            if (res_valid !== 1'b0 || req_ready !== 1'b1)
                $display("[TB] FAIL signed_consume got rv=%b rdy=%b want 0/1", res_valid, req_ready);
            else nPass++;
        end
    endtask

    task automatic test_divu;
        int d0 = dvdBeats[0];
        int s0 = dvsBeats[0];
        int d1 = dvdBeats[1];
        int s1 = dvsBeats[1];
        startOp(2'b11, 32'hFFFF_FFFF, 32'h10);
        nChecks++;
        if (dvd_tvalid !== 2'b10 || dvs_tvalid !== 2'b10)
            $display("[TB] FAIL divu_issue_valid got dvd=%b dvs=%b want 10/10", dvd_tvalid, dvs_tvalid);
        else nPass++;
        tick;
        dout_tdata  = {64'h0, 32'hDEAD_BEEF, 32'hCAFE_F00D};
        dout_tvalid = 2'b01;
        tick;
        nChecks++;
        if (busy !== 1'b1 || res_valid !== 1'b0)
            $display("[TB] FAIL divu_wrong_ip got busy=%b rv=%b want 1/0", busy, res_valid);
        else nPass++;
        dout_tdata  = {32'h0000_000F, 32'h0000_000F, 32'hDEAD_BEEF, 32'hCAFE_F00D};
        dout_tvalid = 2'b10;
        tick;
        dout_tvalid = 2'b00;
        nChecks++;
        if (res_valid !== 1'b1 || res_data !== 32'h0000_000F)
            $display("[TB] FAIL divu_result got rv=%b data=%h want 1/0000000f", res_valid, res_data);
        else nPass++;
        nChecks++;
        if (dvdBeats[0] != d0 || dvsBeats[0] != s0 || dvdBeats[1] != d1 + 1 || dvsBeats[1] != s1 + 1)
            $display("[TB] FAIL divu_beats got ip0=%0d/%0d ip1=%0d/%0d want ip0 +0/+0 ip1 +1/+1",
                     dvdBeats[0] - d0, dvsBeats[0] - s0, dvdBeats[1] - d1, dvsBeats[1] - s1);
        else nPass++;
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
    endtask

    task automatic test_back_pressure;
        int dvdHigh = 0;
        int dvsHigh = 0;
        int d0 = dvdBeats[0];
        int s0 = dvsBeats[0];
        dvd_tready = 2'b11;
        dvs_tready = 2'b00;
        startOp(2'b00, 32'd100, 32'd7);
        for (int c = 0; c < 6; c++) begin
            if (c == 5) dvs_tready = 2'b11;
            dvdHigh += int'(dvd_tvalid[0]);
            dvsHigh += int'(dvs_tvalid[0]);
            tick;
        end
        nChecks++;
        if (dvdHigh != 1 || dvsHigh != 6)
            $display("[TB] FAIL bp_valid_cycles got dvd=%0d dvs=%0d want 1/6", dvdHigh, dvsHigh);
        else nPass++;
        nChecks++;
        if (dvdBeats[0] != d0 + 1 || dvsBeats[0] != s0 + 1)
            $display("[TB] FAIL bp_beats got %0d/%0d want 1/1", dvdBeats[0] - d0, dvsBeats[0] - s0);
        else nPass++;
        nChecks++;
        if (dvs_tvalid !== 2'b00 || busy !== 1'b1)
            $display("[TB] FAIL bp_wait got dvs=%b busy=%b want 00/1", dvs_tvalid, busy);
        else nPass++;
        dout_tdata  = {64'h0, 32'd14, 32'd2};
        dout_tvalid = 2'b01;
        tick;
        dout_tvalid = 2'b00;
        nChecks++;
        if (res_valid !== 1'b1 || res_data !== 32'd14)
            $display("[TB] FAIL bp_result got rv=%b data=%h want 1/0000000e", res_valid, res_data);
        else nPass++;
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
    endtask

    task automatic test_flush_issue;
        int d0 = dvdBeats[0];
        int s0 = dvsBeats[0];
        dvd_tready = 2'b11;
        dvs_tready = 2'b00;
        startOp(2'b00, 32'd50, 32'd5);
        tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        nChecks++;
        if (dvd_tvalid !== 2'b00 || dvs_tvalid !== 2'b01)
            $display("[TB] FAIL flush_half_valid got dvd=%b dvs=%b want 00/01", dvd_tvalid, dvs_tvalid);
        else nPass++;
        dvs_tready = 2'b11;
        tick;
        nChecks++;
        if (dvs_tvalid !== 2'b00 || busy !== 1'b1 || res_valid !== 1'b0)
            $display("[TB] FAIL flush_drain got dvs=%b busy=%b rv=%b want 00/1/0", dvs_tvalid, busy, res_valid);
        else nPass++;
        dout_tdata  = {64'h0, 32'd10, 32'd0};
        dout_tvalid = 2'b01;
        tick;
        dout_tvalid = 2'b00;
        nChecks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || req_ready !== 1'b1)
            $display("[TB] FAIL flush_drain_exit got busy=%b rv=%b rdy=%b want 0/0/1", busy, res_valid, req_ready);
        else nPass++;
        nChecks++;
        if (dvdBeats[0] != d0 + 1 || dvsBeats[0] != s0 + 1)
            $display("[TB] FAIL flush_beats got %0d/%0d want 1/1", dvdBeats[0] - d0, dvsBeats[0] - s0);
        else nPass++;
        // Flush before any beat leaves: abandon outright.
        d0 = dvdBeats[0];
        s0 = dvsBeats[0];
        dvd_tready = 2'b00;
        dvs_tready = 2'b00;
        startOp(2'b00, 32'd9, 32'd3);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        nChecks++;
        if (busy !== 1'b0 || dvd_tvalid !== 2'b00 || dvs_tvalid !== 2'b00 || dvdBeats[0] != d0 || dvsBeats[0] != s0)
            $display("[TB] FAIL flush_unsent got busy=%b dvd=%b dvs=%b want 0/00/00 no beats", busy, dvd_tvalid, dvs_tvalid);
        else nPass++;
        dvd_tready = 2'b11;
        dvs_tready = 2'b11;
    endtask

    task automatic test_done_hold;
        int bad = 0;
        startOp(2'b01, 32'd20, 32'd6);
        tick;
        dout_tdata  = {64'h0, 32'd3, 32'd2};
        dout_tvalid = 2'b01;
        tick;
        dout_tvalid = 2'b00;
        nChecks++;
        if (res_valid !== 1'b1 || res_data !== 32'd2)
            $display("[TB] FAIL hold_result got rv=%b data=%h want 1/00000002", res_valid, res_data);
        else nPass++;
        for (int c = 0; c < 10; c++) begin
            tick;
            if (res_valid !== 1'b1 || res_data !== 32'd2 || req_ready !== 1'b0) bad++;
        end
        nChecks++;
        if (bad != 0)
            $display("[TB] FAIL hold_stable got %0d bad cycles want 0", bad);
        else nPass++;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        nChecks++;
        if (res_valid !== 1'b0 || busy !== 1'b0)
            $display("[TB] FAIL hold_flush got rv=%b busy=%b want 0/0", res_valid, busy);
        else nPass++;
    endtask

    task automatic test_flush_idle;
        req_op    = 2'b00;
        req_src1  = 32'd1;
        req_src2  = 32'd1;
        req_valid = 1'b1;
        flush     = 1'b1;
        tick;
        req_valid = 1'b0;
        flush     = 1'b0;
        nChecks++;
        if (busy !== 1'b0 || dvd_tvalid !== 2'b00)
            $display("[TB] FAIL flush_idle got busy=%b dvd=%b want 0/00", busy, dvd_tvalid);
        else nPass++;
    endtask

    task automatic test_watchdog;
        logic errEarly = 1'b0;
        startOp(2'b00, 32'd8, 32'd2);
        tick;
        for (int k = 1; k <= 64; k++) begin
            if (err) errEarly = 1'b1;
            tick;
        end
        nChecks++;
        if (errEarly !== 1'b0)
            $display("[TB] FAIL wd_early got err before limit=%b want 0", errEarly);
        else nPass++;
        nChecks++;
        if (err !== 1'b1 || busy !== 1'b1)
            $display("[TB] FAIL wd_pulse got err=%b busy=%b want 1/1", err, busy);
        else nPass++;
        tick;
        nChecks++;
        if (err !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1)
            $display("[TB] FAIL wd_exit got err=%b busy=%b rdy=%b want 0/0/1", err, busy, req_ready);
        else nPass++;
    endtask

    task automatic test_reset_mid;
        startOp(2'b00, 32'd12, 32'd4);
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        nChecks++;
        if ({req_ready, busy, res_valid, err} !== 4'b1000 || res_data !== 32'h0 || {dvd_tvalid, dvs_tvalid} !== 4'b0)
            $display("[TB] FAIL reset_mid got rdy/busy/rv/err=%b data=%h want 1000/0",
                     {req_ready, busy, res_valid, err}, res_data);
        else nPass++;
        dout_tdata  = {64'h0, 32'd3, 32'd0};
        dout_tvalid = 2'b01;
        tick;
        dout_tvalid = 2'b00;
        nChecks++;
        if (busy !== 1'b0 || res_valid !== 1'b0)
            $display("[TB] FAIL reset_stale got busy=%b rv=%b want 0/0", busy, res_valid);
        else nPass++;
    endtask

    initial begin
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_op      = 2'b00;
        req_src1    = '0;
        req_src2    = '0;
        flush       = 1'b0;
        res_ready   = 1'b0;
        dvd_tready  = 2'b11;
        dvs_tready  = 2'b11;
        dout_tvalid = 2'b00;
        dout_tdata  = '0;
        test_reset;
        test_div_signed;
        test_divu;
        test_back_pressure;
        test_flush_issue;
        test_done_hold;
        test_flush_idle;
        test_watchdog;
        test_reset_mid;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
